// File: rtl/wb_arbiter.sv
// Writeback arbiter: two buffered result sources with round-robin selection,
// emitting one registered register-file write and a done pulse per grant.
module wb_arbiter #(
  parameter int NUM_LANES  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 4,
  parameter int WARP_W     = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s0_valid,
  output logic                            s0_ready,
  input  logic [WARP_W-1:0]               s0_warp,
  input  logic [ADDR_W-1:0]               s0_reg,
  input  logic [NUM_LANES-1:0]            s0_mask,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] s0_data,
  input  logic                            s1_valid,
  output logic                            s1_ready,
  input  logic [WARP_W-1:0]               s1_warp,
  input  logic [ADDR_W-1:0]               s1_reg,
  input  logic [NUM_LANES-1:0]            s1_mask,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] s1_data,
  input  logic                            wb_stall,
  output logic [NUM_LANES-1:0]            write_en,
  output logic [ADDR_W-1:0]               waddr,
  output logic [WARP_W-1:0]               warp_sel,
  output logic [NUM_LANES*DATA_WIDTH-1:0] wdata,
  output logic                            done_valid,
  output logic [WARP_W-1:0]               done_warp,
  output logic [ADDR_W-1:0]               done_reg,
  output logic                            done_src
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [WARP_W-1:0]               warp;
    logic [ADDR_W-1:0]               rg;
    logic [NUM_LANES-1:0]            mask;
    logic [NUM_LANES*DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_e;

  entry_t     in_e [2];
  entry_t     head [2];
  logic [1:0] in_valid;
  logic [1:0] ready;
  logic [1:0] nonempty;
  logic [1:0] elig;
  logic [1:0] pop;
  logic       grant;
  src_e       gsel;
  src_e       last;
  entry_t     g;

  assign in_e[0]  = {s0_warp, s0_reg, s0_mask, s0_data};
  assign in_e[1]  = {s1_warp, s1_reg, s1_mask, s1_data};
  assign in_valid = {s1_valid, s0_valid};
  assign s0_ready = ready[0];
  assign s1_ready = ready[1];

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;

    // Ready looks at count only; a full FIFO refuses even while it pops.
    assign ready[s]    = count < DEPTH_C;
    assign push        = in_valid[s] && ready[s];
    assign nonempty[s] = count != '0;
    assign head[s]     = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_e[s];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop[s]) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop[s])      count <= count + 1'b1;
        else if (!push && pop[s]) count <= count - 1'b1;
      end
    end
  end

  always_comb begin
    elig  = nonempty & {2{~wb_stall}};
    grant = |elig;
    gsel  = SRC0;
    if (elig == 2'b11) gsel = (last == SRC0) ? SRC1 : SRC0;
    else if (elig[1])  gsel = SRC1;
    pop = 2'b00;
    if (grant) pop = (gsel == SRC1) ? 2'b10 : 2'b01;
    g = (gsel == SRC1) ? head[1] : head[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_en   <= '0;
      waddr      <= '0;
      warp_sel   <= '0;
      wdata      <= '0;
      done_valid <= 1'b0;
      done_warp  <= '0;
      done_reg   <= '0;
      done_src   <= 1'b0;
      last       <= SRC1;
    end else if (grant) begin
      write_en   <= g.mask;
      waddr      <= g.rg;
      warp_sel   <= g.warp;
      wdata      <= g.data;
      done_valid <= 1'b1;
      done_warp  <= g.warp;
      done_reg   <= g.rg;
      done_src   <= (gsel == SRC1);
      last       <= gsel;
    end else begin
      write_en   <= '0;
      done_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_arbiter;
  localparam int NL = 16;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int WW = 3;
  localparam int D  = 2;
  localparam int BW = NL * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s0_valid, s1_valid, s0_ready, s1_ready, wb_stall;
  logic [WW-1:0] s0_warp, s1_warp, warp_sel, done_warp;
  logic [AW-1:0] s0_reg, s1_reg, waddr, done_reg;
  logic [NL-1:0] s0_mask, s1_mask, write_en;
  logic [BW-1:0] s0_data, s1_data, wdata;
  logic          done_valid, done_src;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_W(AW), .WARP_W(WW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_warp(s0_warp), .s0_reg(s0_reg),
    .s0_mask(s0_mask), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_warp(s1_warp), .s1_reg(s1_reg),
    .s1_mask(s1_mask), .s1_data(s1_data),
    .wb_stall(wb_stall), .write_en(write_en), .waddr(waddr), .warp_sel(warp_sel),
    .wdata(wdata), .done_valid(done_valid), .done_warp(done_warp), .done_reg(done_reg),
    .done_src(done_src)
  );

  typedef struct {
    logic [WW-1:0] warp;
    logic [AW-1:0] rg;
    logic [NL-1:0] mask;
    logic [BW-1:0] data;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  bit   last_src;
  ent_t h;
  int   n0, n1;
  bit   e0, e1, sel;

  logic [NL-1:0] x_we;
  logic [AW-1:0] x_waddr, x_dreg;
  logic [WW-1:0] x_warp, x_dwarp;
  logic [BW-1:0] x_wdata;
  logic          x_dv, x_dsrc;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  task automatic cmp(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: per-source queues, round-robin on ties, registered outputs.
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      q0.delete();
      q1.delete();
      last_src = 1;
      x_we = '0; x_waddr = '0; x_warp = '0; x_wdata = '0;
      x_dv = 0; x_dwarp = '0; x_dreg = '0; x_dsrc = 0;
    end else begin
      n0 = q0.size();
      n1 = q1.size();
      e0 = (n0 > 0) && !wb_stall;
      e1 = (n1 > 0) && !wb_stall;
      if (e0 || e1) begin
        sel = (e0 && e1) ? !last_src : e1;
        h = sel ? q1.pop_front() : q0.pop_front();
        last_src = sel;
        x_we = h.mask; x_waddr = h.rg; x_warp = h.warp; x_wdata = h.data;
        x_dv = 1; x_dwarp = h.warp; x_dreg = h.rg; x_dsrc = sel;
      end else begin
        x_we = '0;
        x_dv = 0;
      end
      if (s0_valid && n0 < D) q0.push_back('{s0_warp, s0_reg, s0_mask, s0_data});
      if (s1_valid && n1 < D) q1.push_back('{s1_warp, s1_reg, s1_mask, s1_data});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      cmp("write_en",   write_en,   x_we);
      cmp("waddr",      waddr,      x_waddr);
      cmp("warp_sel",   warp_sel,   x_warp);
      cmp("wdata",      wdata,      x_wdata);
      cmp("done_valid", done_valid, x_dv);
      cmp("done_warp",  done_warp,  x_dwarp);
      cmp("done_reg",   done_reg,   x_dreg);
      cmp("done_src",   done_src,   x_dsrc);
      cmp("s0_ready",   s0_ready,   q0.size() < D);
      cmp("s1_ready",   s1_ready,   q1.size() < D);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] ramp(input int base);
    logic [BW-1:0] d;
    for (int i = 0; i < NL; i++) d[i*DW +: DW] = DW'(base + i);
    return d;
  endfunction

  task automatic set0(input logic v, input int w, input int r, input logic [NL-1:0] m, input logic [BW-1:0] d);
    s0_valid = v; s0_warp = WW'(w); s0_reg = AW'(r); s0_mask = m; s0_data = d;
  endtask

  task automatic set1(input logic v, input int w, input int r, input logic [NL-1:0] m, input logic [BW-1:0] d);
    s1_valid = v; s1_warp = WW'(w); s1_reg = AW'(r); s1_mask = m; s1_data = d;
  endtask

  logic          src_log [4];
  logic [AW-1:0] reg_log [4];
  logic [BW-1:0] rd;
  logic [31:0]   lane5;

  initial begin
    wb_stall = 0;
    set1(0, 0, 0, '0, '0);
    // Reset with s0 offering data: nothing may be written afterwards.
    set0(1, 1, 1, 16'hFFFF, ramp(32'h500));
    tick(); tick();
    rst = 0; s0_valid = 0;
    cmp("rst_write_en", write_en, 0);
    cmp("rst_done_valid", done_valid, 0);
    cmp("rst_s0_ready", s0_ready, 1);
    tick(); tick();
    cmp("rst_no_write", done_valid, 0);

    // Single write: visible after the edge following acceptance.
    set0(1, 3, 4'hA, 16'hFFFF, ramp(32'h1000));
    tick();
    s0_valid = 0;
    tick();
    lane5 = wdata[5*DW +: DW];
    cmp("single_we", write_en, 16'hFFFF);
    cmp("single_warp", warp_sel, 3);
    cmp("single_waddr", waddr, 4'hA);
    cmp("single_lane5", lane5, 32'h1005);
    cmp("single_dv", done_valid, 1);
    cmp("single_src", done_src, 0);
    tick();
    cmp("single_we_off", write_en, 0);

    // Round-robin from a fresh pointer.
    rst = 1; tick(); rst = 0;
    wb_stall = 1;
    set0(1, 0, 8, 16'hFFFF, ramp(32'h2000));
    set1(1, 1, 1, 16'h00FF, ramp(32'h3000));
    tick();
    set0(1, 0, 9, 16'hFFFF, ramp(32'h2100));
    set1(1, 1, 2, 16'h00FF, ramp(32'h3100));
    tick();
    s0_valid = 0; s1_valid = 0; wb_stall = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      src_log[i] = done_src;
      reg_log[i] = done_reg;
      cmp("rr_dv", done_valid, 1);
    end
    cmp("rr_src0", src_log[0], 0); cmp("rr_reg0", reg_log[0], 8);
    cmp("rr_src1", src_log[1], 1); cmp("rr_reg1", reg_log[1], 1);
    cmp("rr_src2", src_log[2], 0); cmp("rr_reg2", reg_log[2], 9);
    cmp("rr_src3", src_log[3], 1); cmp("rr_reg3", reg_log[3], 2);
    wb_stall = 1;
    set0(1, 4, 11, 16'h1, ramp(32'h4000));
    set1(1, 5, 12, 16'h2, ramp(32'h5000));
    tick();
    s0_valid = 0; s1_valid = 0; wb_stall = 0;
    tick();
    cmp("rr_tie_src", done_src, 0);
    tick(); tick();

    // Full FIFO under stall; third entry held until space frees.
    wb_stall = 1;
    set1(1, 2, 5, 16'hF0F0, ramp(32'h6000)); tick();
    set1(1, 2, 6, 16'hF0F0, ramp(32'h6100)); tick();
    cmp("full_ready_a", s1_ready, 0);
    set1(1, 2, 7, 16'hF0F0, ramp(32'h6200)); tick();
    cmp("full_ready_b", s1_ready, 0);
    tick();
    cmp("full_ready_c", s1_ready, 0);
    wb_stall = 0;
    tick();
    cmp("full_pop1_reg", done_reg, 5);
    cmp("full_ready_back", s1_ready, 1);
    tick();
    s1_valid = 0;
    cmp("full_pop2_reg", done_reg, 6);
    tick();
    cmp("full_pop3_reg", done_reg, 7);
    tick();

    // Stall gap with both FIFOs occupied; waddr holds the last write.
    wb_stall = 1;
    set0(1, 1, 3, 16'hFFFF, ramp(32'h7000));
    set1(1, 1, 4, 16'hFFFF, ramp(32'h8000));
    tick();
    s0_valid = 0; s1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("stall_we", write_en, 0);
      cmp("stall_dv", done_valid, 0);
      cmp("stall_waddr", waddr, 7);
    end
    wb_stall = 0;
    tick();
    cmp("stall_resume", done_valid, 1);
    tick(); tick();

    // Zero mask still pops and pulses done.
    set0(1, 2, 4'hC, 16'h0000, ramp(32'h9000));
    tick();
    s0_valid = 0;
    tick();
    cmp("zmask_dv", done_valid, 1);
    cmp("zmask_we", write_en, 0);
    cmp("zmask_reg", done_reg, 4'hC);
    tick();

    // Reset with entries queued discards them.
    wb_stall = 1;
    set0(1, 6, 1, 16'hFFFF, ramp(32'hA000));
    set1(1, 6, 2, 16'hFFFF, ramp(32'hB000));
    tick();
    s0_valid = 0; s1_valid = 0;
    rst = 1; wb_stall = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("midrst_dv", done_valid, 0);
      cmp("midrst_s0_ready", s0_ready, 1);
      cmp("midrst_s1_ready", s1_ready, 1);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      wb_stall = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NL; i++) rd[i*DW +: DW] = $urandom();
      set0($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 15),
           ($urandom_range(0, 7) == 0) ? 16'h0 : NL'($urandom()), rd);
      for (int i = 0; i < NL; i++) rd[i*DW +: DW] = $urandom();
      set1($urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom_range(0, 15),
           ($urandom_range(0, 7) == 0) ? 16'h0 : NL'($urandom()), rd);
      tick();
    end
    rst = 0; wb_stall = 0; s0_valid = 0; s1_valid = 0;
    repeat (6) tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
